neuron_accumulate_unit: RTL and testbench
=========================================

Name: neuron_accumulate_unit

Overview:
Downstream consumer of the bias-vector manager. It multiply-accumulates a stream of Q8.8 activation/weight pairs for one output neuron and drives the bias vector/element index to the bias-vector manager. It adds the registered bias element it gets back, then requantizes, saturates and optionally rectifies the sum. The result leaves through a valid/ready handshake toward the layer-output writer.

Parameters:
DATA_W, 16, width of activations, weights, bias and result (signed two's complement)
FRAC_W, 8, fractional bits (Q8.8)
ACC_W, 40, signed accumulator width
N_ELEM, 16, maximum products per neuron
IDX_W, 4, width of element/neuron index

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin neuron; sampled only in IDLE
vector_index_in  in  2  layer/vector select, latched on start
neuron_index  in  IDX_W  output neuron number, latched on start
in_valid  in  1  product operands valid
in_ready  out  1  accepting operands
in_last  in  1  marks final operand pair of the neuron
a_element  in  DATA_W  activation, signed Q8.8
w_element  in  DATA_W  weight, signed Q8.8
b_vector_index  out  2  to bias manager vector_index
b_element_index  out  IDX_W  to bias manager element_index
b_element  in  DATA_W  registered bias from bias manager
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_element  out  DATA_W  result, signed Q8.8
out_neuron_index  out  IDX_W  neuron of result
overflow  out  1  result was saturated; qualified by out_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-low): state IDLE; acc, count, latched indices, out_element, out_neuron_index cleared to 0; out_valid, overflow, busy, in_ready all 0.
- FSM states: IDLE, ACCUM, BIAS, OUT.
- IDLE -> ACCUM on start. Latch vector_index_in and neuron_index. Clear acc and count.
- b_vector_index / b_element_index come straight from the latched registers and stay stable from IDLE exit until return to IDLE.
- ACCUM: in_ready=1. On in_valid&&in_ready:
  - acc += sign-extended full DATA_W*2 product a*w, kept at 2*FRAC_W fractional bits.
  - count += 1.
  - If in_last or count==N_ELEM-1 -> BIAS.
  - At N_ELEM accepted pairs the neuron terminates even without in_last; in_ready drops on the next cycle.
- BIAS (one cycle, in_ready=0):
  - sum = acc + (sign-extended b_element << FRAC_W).
  - sum arithmetic-shifted right by FRAC_W (truncation toward −inf).
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; overflow=1 if clamped.
  - Register out_element and out_neuron_index. Go to OUT.
  - b_element is guaranteed valid here: the index has been stable for ≥2 edges.
- OUT: out_valid=1. out_element, out_neuron_index and overflow are held stable until out_ready. On out_valid&&out_ready -> IDLE and out_valid falls.
- Latency: last operand accepted at edge t -> out_valid high in the cycle after edge t+1.
- start while not IDLE is ignored. start in the OUT handshake cycle is ignored and must be re-asserted in IDLE.
- in_valid outside ACCUM is ignored (in_ready=0); no operand is consumed.
- Reset mid-operation aborts the neuron: no out_valid pulse, acc discarded.
- Accumulator never wraps for N_ELEM≤256 at ACC_W=40; any larger ACC_W/N_ELEM combination must satisfy ACC_W ≥ 2*DATA_W+clog2(N_ELEM)+1.

Optional Feature:
NEURON_RELU_EN. When defined, a saturated negative result is replaced by 0 before registering, and overflow reflects only positive clamping. When undefined, the signed saturated value passes unchanged. The requantization path is otherwise identical.

Decomposition:
- Shared package nn_pkg: DATA_W, FRAC_W, ACC_W, N_ELEM, IDX_W constants; FSM state typedef (IDLE/ACCUM/BIAS/OUT); Q8.8 one constant 16'h0100.
- One natural sub-module: fixed_point_requant. It is combinational: ACC_W sum in -> shift, saturate, optional ReLU -> DATA_W result plus overflow flag. It is reused by other layer stages.

Test Plan:
- Basic: start, neuron 3, vector 1; pairs (0x0100,0x0200), (0x0080,0x0100, in_last); b_element=0x0100 -> b_element_index=3, b_vector_index=1; out_element=0x0380 (3.5), out_neuron_index=3, overflow=0.
- Saturation: 16 pairs (0x7FFF,0x7FFF), bias 0x7FFF -> out_element=0x7FFF, overflow=1. Negative case: 16 pairs (0x8000,0x7FFF) -> 0x8000 without ReLU.
- ReLU: pair (0x0100,0xFE00, in_last), bias 0x0080 -> 0xFE80 with macro undefined; 0x0000 with NEURON_RELU_EN defined.
- Backpressure: out_ready low 5 cycles -> out_valid high and out_element stable for all 5 cycles; start pulses during OUT ignored; handshake then IDLE.
- Element limit: 16 valid pairs (0x0100,0x0100), in_last never asserted, bias 0 -> in_ready low after the 16th pair, out_element=0x1000.
- Reset mid-ACCUM: assert reset_n low after 5 pairs -> busy, in_ready, out_valid go 0 immediately. A following neuron with one pair (0x0100,0x0100), bias 0 gives 0x0100 (no residue).

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the neural-network layer stages.
// Q8.8 fixed point throughout; accumulation is done at Q(2*FRAC_W) resolution.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int N_ELEM = 16;
  localparam int IDX_W  = 4;
  localparam int VEC_W  = 2;

  localparam logic [DATA_W-1:0] Q_ONE = 16'h0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Full-precision signed product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] w);
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(w);
    return ACC_W'(p);
  endfunction

endpackage

// File: rtl/neuron_accumulate_unit_if.sv
// Bundles the operand stream, bias-manager link and result stream of one neuron unit.
// slave = the accumulate unit, master = the surrounding layer logic.
interface neuron_accumulate_unit_if;
  import nn_pkg::*;

  logic                 start;
  logic [VEC_W-1:0]     vector_index_in;
  logic [IDX_W-1:0]     neuron_index;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [DATA_W-1:0]    a_element;
  logic [DATA_W-1:0]    w_element;

  logic [VEC_W-1:0]     b_vector_index;
  logic [IDX_W-1:0]     b_element_index;
  logic [DATA_W-1:0]    b_element;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_element;
  logic [IDX_W-1:0]     out_neuron_index;
  logic                 overflow;
  logic                 busy;

  modport slave (
    input  start, vector_index_in, neuron_index,
    input  in_valid, in_last, a_element, w_element,
    output in_ready,
    output b_vector_index, b_element_index,
    input  b_element,
    output out_valid, out_element, out_neuron_index, overflow, busy,
    input  out_ready
  );

  modport master (
    output start, vector_index_in, neuron_index,
    output in_valid, in_last, a_element, w_element,
    input  in_ready,
    input  b_vector_index, b_element_index,
    output b_element,
    input  out_valid, out_element, out_neuron_index, overflow, busy,
    output out_ready
  );

endinterface

// File: rtl/fixed_point_requant.sv
// Combinational requantizer: arithmetic shift, signed saturation, optional ReLU.
// Define NEURON_RELU_EN to clamp negative results to zero.
module fixed_point_requant
  import nn_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = DATA_W,
  parameter int SHIFT = FRAC_W
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [OUT_W-1:0] result,
  output logic                    overflow
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // >>> on a signed operand truncates toward -inf, which is the intended rounding.
  assign shifted = sum >>> SHIFT;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    result   = shifted[OUT_W-1:0];
    overflow = 1'b0;
    if (shifted > MAX_V) begin
      result   = {1'b0, {(OUT_W-1){1'b1}}};
      overflow = 1'b1;
    end else if (shifted < MIN_V) begin
      result   = {1'b1, {(OUT_W-1){1'b0}}};
      overflow = 1'b1;
    end
`ifdef NEURON_RELU_EN
    if (result[OUT_W-1]) begin
      result   = '0;
      overflow = 1'b0;
    end
`else
`endif
  end

endmodule

// File: rtl/neuron_accumulate_unit.sv
// Multiply-accumulates Q8.8 operand pairs for one neuron, adds the bias element,
// requantizes and hands the result out over valid/ready. Optional: NEURON_RELU_EN.
module neuron_accumulate_unit
  import nn_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  neuron_accumulate_unit_if.slave   bus
);

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N_ELEM - 1);

  if (ACC_W < 2*DATA_W + $clog2(N_ELEM) + 1) begin : g_acc_width_check
    $error("ACC_W too narrow: accumulator could wrap for N_ELEM products");
  end

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [IDX_W:0]           count_q;
  logic [VEC_W-1:0]         vec_q;
  logic [IDX_W-1:0]         neuron_q;
  logic [DATA_W-1:0]        out_element_q;
  logic [IDX_W-1:0]         out_neuron_q;
  logic                     overflow_q;

  logic                     accept;
  logic                     last_pair;
  logic signed [ACC_W-1:0]  bias_aligned;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] req_result;
  logic                     req_overflow;

  assign accept       = bus.in_valid && (state_q == ACCUM);
  assign last_pair    = bus.in_last || (count_q == LAST_CNT);
  assign bias_aligned = ACC_W'($signed(bus.b_element)) <<< FRAC_W;
  assign sum          = acc_q + bias_aligned;

  fixed_point_requant #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (FRAC_W)
  ) u_requant (
    .sum      (sum),
    .result   (req_result),
    .overflow (req_overflow)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start)              state_d = ACCUM;
      ACCUM: if (accept && last_pair)    state_d = BIAS;
      BIAS:                              state_d = OUT;
      OUT:   if (bus.out_ready)          state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      count_q       <= '0;
      vec_q         <= '0;
      neuron_q      <= '0;
      out_element_q <= '0;
      out_neuron_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            vec_q    <= bus.vector_index_in;
            neuron_q <= bus.neuron_index;
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q   <= acc_q + mul_ext($signed(bus.a_element), $signed(bus.w_element));
            count_q <= count_q + 1'b1;
          end
        end
        BIAS: begin
          // Bias index has been stable since start, so b_element is settled here.
          out_element_q <= req_result;
          out_neuron_q  <= neuron_q;
          overflow_q    <= req_overflow;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready         = (state_q == ACCUM);
  assign bus.out_valid        = (state_q == OUT);
  assign bus.busy             = (state_q != IDLE);
  assign bus.b_vector_index   = vec_q;
  assign bus.b_element_index  = neuron_q;
  assign bus.out_element      = out_element_q;
  assign bus.out_neuron_index = out_neuron_q;
  assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_neuron_accumulate_unit.sv
// Self-checking bench for neuron_accumulate_unit: vector table, scoreboard, corner sequences.
// Expectations follow NEURON_RELU_EN when the build defines it.
module tb_neuron_accumulate_unit;
  import nn_pkg::*;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clock;
  logic reset_n;

  neuron_accumulate_unit_if bus ();

  neuron_accumulate_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  vec;
    logic [3:0]  neu;
    int          n;
    logic [15:0] a0;
    logic [15:0] w0;
    logic [15:0] a1;
    logic [15:0] w1;
    logic [15:0] bias;
    bit          use_last;
    logic [15:0] exp_elem;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] elem;
    logic [3:0]  neu;
    logic        ovf;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [15:0] bias_mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered bias-manager model.
  always @(posedge clock) bus.b_element <= bias_mem[{bus.b_vector_index, bus.b_element_index}];

  // Scoreboard consumer: compares each accepted result against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_element", {16'd0, bus.out_element}, {16'd0, e.elem});
        check("out_neuron_index", {28'd0, bus.out_neuron_index}, {28'd0, e.neu});
        check("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_neuron(input logic [1:0] vec, input logic [3:0] neu);
    bus.start           = 1'b1;
    bus.vector_index_in = vec;
    bus.neuron_index    = neu;
    tick();
    bus.start           = 1'b0;
    bus.vector_index_in = '0;
    bus.neuron_index    = '0;
  endtask

  task automatic feed(input int n, input logic [15:0] a0, input logic [15:0] w0,
                      input logic [15:0] a1, input logic [15:0] w1, input bit use_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = 1'b1;
      bus.a_element = (i == 0) ? a0 : a1;
      bus.w_element = (i == 0) ? w0 : w1;
      bus.in_last   = use_last && (i == n - 1);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.a_element = '0;
    bus.w_element = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vector(input vec_t r);
    exp_t e;
    bias_mem[{r.vec, r.neu}] = r.bias;
    e.elem = r.exp_elem;
    e.neu  = r.neu;
    e.ovf  = r.exp_ovf;
    sb_q.push_back(e);
    start_neuron(r.vec, r.neu);
    check("b_vector_index", {30'd0, bus.b_vector_index}, {30'd0, r.vec});
    check("b_element_index", {28'd0, bus.b_element_index}, {28'd0, r.neu});
    feed(r.n, r.a0, r.w0, r.a1, r.w1, r.use_last);
    @(negedge clock);
    check("in_ready_after_last", {31'd0, bus.in_ready}, 32'd0);
    check("busy_in_bias", {31'd0, bus.busy}, 32'd1);
    @(negedge clock);
    check("out_valid_latency", {31'd0, bus.out_valid}, 32'd1);
    wait_idle("vector");
  endtask

  vec_t tbl [6];

  initial begin
    for (int i = 0; i < 64; i++) bias_mem[i] = '0;
    reset_n             = 1'b0;
    bus.start           = 1'b0;
    bus.vector_index_in = '0;
    bus.neuron_index    = '0;
    bus.in_valid        = 1'b0;
    bus.in_last         = 1'b0;
    bus.a_element       = '0;
    bus.w_element       = '0;
    bus.out_ready       = 1'b1;

    //          vec   neu    n   a0       w0       a1       w1       bias     last  exp            ovf
    tbl[0] = '{2'd1, 4'd3,  2,  16'h0100, 16'h0200, 16'h0080, 16'h0100, 16'h0100, 1'b1, 16'h0380, 1'b0};
    tbl[1] = '{2'd0, 4'd5,  16, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    tbl[2] = '{2'd2, 4'd6,  16, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 1'b1,
               RELU ? 16'h0000 : 16'h8000, !RELU};
    tbl[3] = '{2'd3, 4'd7,  1,  16'h0100, 16'hFE00, 16'h0100, 16'hFE00, 16'h0080, 1'b1,
               RELU ? 16'h0000 : 16'hFE80, 1'b0};
    tbl[4] = '{2'd0, 4'd15, 16, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1000, 1'b0};
    tbl[5] = '{2'd1, 4'd2,  1,  16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b1,
               RELU ? 16'h0000 : 16'hFFFF, 1'b0};

    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_out_element", {16'd0, bus.out_element}, 32'd0);
    check("rst_out_neuron", {28'd0, bus.out_neuron_index}, 32'd0);
    check("rst_b_index", {26'd0, bus.b_vector_index, bus.b_element_index}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vector(tbl[i]);

    // Backpressure: result held for 5 cycles while start pulses are ignored.
    begin
      exp_t e;
      bit seen;
      bias_mem[{2'd2, 4'd9}] = 16'h0000;
      e.elem = 16'h0300;
      e.neu  = 4'd9;
      e.ovf  = 1'b0;
      sb_q.push_back(e);
      bus.out_ready = 1'b0;
      start_neuron(2'd2, 4'd9);
      feed(1, 16'h0200, 16'h0180, 16'h0200, 16'h0180, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clock);
        if (bus.out_valid) seen = 1'b1;
      end
      check("bp_out_valid_seen", {31'd0, seen}, 32'd1);
      for (int c = 0; c < 5; c++) begin
        bus.start = 1'b1;
        bus.neuron_index = 4'd1;
        @(negedge clock);
        check("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
        check("bp_out_element_held", {16'd0, bus.out_element}, 32'h0300);
        check("bp_out_neuron_held", {28'd0, bus.out_neuron_index}, 32'd9);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.neuron_index = '0;
      @(negedge clock);
      check("bp_idle_after_hs", {31'd0, bus.busy}, 32'd0);
      check("bp_out_valid_fell", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clock);
      check("bp_start_ignored", {31'd0, bus.busy}, 32'd0);
    end

    // Reset mid-ACCUM aborts the neuron; stray in_valid in IDLE consumes nothing.
    tick();
    start_neuron(2'd1, 4'd4);
    feed(5, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid  = 1'b1;
    bus.a_element = 16'h7FFF;
    bus.w_element = 16'h7FFF;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("idle_in_valid_ignored", {31'd0, bus.busy}, 32'd0);
    bus.in_valid  = 1'b0;
    tick();
    begin
      vec_t r;
      r = '{2'd1, 4'd4, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h0100, 1'b0};
      run_vector(r);
    end

    repeat (2) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
